ctrl_fsm: RTL and testbench

Multicycle control state machine for the RV32I core. It sequences instruction fetch into the instruction register, then decode, execute, memory access and writeback. It drives every datapath select and enable from the 7-bit opcode returned by the instruction register. It sits beside the datapath and owns the single shared memory port through a req/ready handshake.

---
 rtl/ctrl_pkg.sv | 157 +++++++++++++++
 rtl/ctrl_if.sv | 17 +
 rtl/ctrl_opdec.sv | 40 ++++
 rtl/ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the RV32I multicycle control unit:
//   - state_t     : 4-bit FSM state encoding (FETCH = 0)
//   - OP_*        : RV32I major opcodes (instruction bits [6:0])
//   - *_t enums   : datapath select encodings (ALU operands/op, writeback, PC)
//   - op_class_t  : opcode class produced by ctrl_opdec
//   - sel_t       : the state-only datapath selects, registered in ctrl_fsm
//   - sel_for()   : select values for a given state
// -----------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_EXEC_R   = 4'd6,
      ST_EXEC_I   = 4'd7,
      ST_UPPER    = 4'd8,
      ST_ALU_WB   = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JAL      = 4'd11,
      ST_JALR     = 4'd12,
      ST_TRAP     = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_RS1    = 2'd1,
      SRC_A_OLD_PC = 2'd2,
      SRC_A_ZERO   = 2'd3
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'd0,
      SRC_B_IMM  = 2'd1,
      SRC_B_FOUR = 2'd2
   } alu_src_b_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_BRANCH = 2'd1,
      ALU_FUNCT  = 2'd2
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'd0,
      WB_MEM    = 2'd1,
      WB_LINK   = 2'd2
   } wb_sel_t;

   typedef enum logic {
      PC_ALU    = 1'b0,
      PC_ALUOUT = 1'b1
   } pc_sel_t;

   typedef enum logic [2:0] {
      CLS_MEM,
      CLS_R,
      CLS_I,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_UPPER,
      CLS_ILLEGAL
   } op_class_t;

   // Selects that depend on state only.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      pc_sel_t    pc_sel;
      wb_sel_t    wb_sel;
      alu_src_a_t alu_src_a;
      alu_src_b_t alu_src_b;
      alu_op_t    alu_op;
   } sel_t;

   // is_lui only matters in UPPER, where it picks zero (LUI) or old_pc (AUIPC).
   function automatic sel_t sel_for(state_t s, logic is_lui);
      sel_t r;
      r = '0;
      case (s)
         ST_FETCH: begin
            r.mem_req   = 1'b1;
            r.alu_src_a = SRC_A_PC;
            r.alu_src_b = SRC_B_FOUR;
         end
         ST_DECODE: begin
            r.alu_src_a = SRC_A_OLD_PC;
            r.alu_src_b = SRC_B_IMM;
         end
         ST_MEM_ADDR: begin
            r.alu_src_a = SRC_A_RS1;
            r.alu_src_b = SRC_B_IMM;
         end
         ST_MEM_RD: begin
            r.mem_req  = 1'b1;
            r.addr_sel = 1'b1;
         end
         ST_MEM_WB: r.wb_sel = WB_MEM;
         ST_MEM_WR: begin
            r.mem_req  = 1'b1;
            r.mem_we   = 1'b1;
            r.addr_sel = 1'b1;
         end
         ST_EXEC_R: begin
            r.alu_src_a = SRC_A_RS1;
            r.alu_src_b = SRC_B_RS2;
            r.alu_op    = ALU_FUNCT;
         end
         ST_EXEC_I: begin
            r.alu_src_a = SRC_A_RS1;
            r.alu_src_b = SRC_B_IMM;
            r.alu_op    = ALU_FUNCT;
         end
         ST_UPPER: begin
            r.alu_src_a = is_lui ? SRC_A_ZERO : SRC_A_OLD_PC;
            r.alu_src_b = SRC_B_IMM;
         end
         ST_ALU_WB: r.wb_sel = WB_ALUOUT;
         ST_BRANCH: begin
            r.alu_src_a = SRC_A_RS1;
            r.alu_src_b = SRC_B_RS2;
            r.alu_op    = ALU_BRANCH;
            r.pc_sel    = PC_ALUOUT;
         end
         ST_JAL: begin
            r.pc_sel = PC_ALUOUT;
            r.wb_sel = WB_LINK;
         end
         ST_JALR: begin
            r.alu_src_a = SRC_A_RS1;
            r.alu_src_b = SRC_B_IMM;
            r.pc_sel    = PC_ALU;
            r.wb_sel    = WB_LINK;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ctrl_if.sv
// -----------------------------------------------------------------------------
// ctrl_if
// Shared memory port handshake between the control unit and memory.
//   mem_req   : request (master -> slave)
//   mem_we    : write request, meaningful only with mem_req
//   addr_sel  : address source, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current request this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface ctrl_if;
   logic mem_req;
   logic mem_we;
   logic addr_sel;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
   modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_opdec.sv
// -----------------------------------------------------------------------------
// ctrl_opdec
// Combinational opcode classifier used by DECODE and MEM_ADDR.
//   opcode   in  7 : instruction bits [6:0]
//   op_class out 3 : class selecting the state after DECODE
//   illegal  out 1 : opcode is not an RV32I major opcode handled here
//   is_load  out 1 : opcode is a load (MEM_ADDR -> MEM_RD)
//   is_lui   out 1 : opcode is LUI (UPPER uses zero as operand A)
// -----------------------------------------------------------------------------
module ctrl_opdec
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class,
   output logic       illegal,
   output logic       is_load,
   output logic       is_lui
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      op_class = CLS_ILLEGAL;
      illegal  = 1'b0;
      case (opcode)
         OP_LOAD, OP_STORE: op_class = CLS_MEM;
         OP_R:              op_class = CLS_R;
         OP_I:              op_class = CLS_I;
         OP_BRANCH:         op_class = CLS_BRANCH;
         OP_JAL:            op_class = CLS_JAL;
         OP_JALR:           op_class = CLS_JALR;
         OP_LUI, OP_AUIPC:  op_class = CLS_UPPER;
         default:           illegal  = 1'b1;
      endcase
   end

   assign is_load = (opcode == OP_LOAD);
   assign is_lui  = (opcode == OP_LUI);

endmodule

// File: rtl/ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ctrl_fsm
// Multicycle control FSM for the RV32I core: FETCH, DECODE, execute, memory
// and writeback sequencing, plus a memory wait-timeout.
// Parameters:
//   MEM_WAIT_MAX : wait cycles before a memory access is aborted (0 = never), 0..255
// Configuration macro:
//   CTRL_TRAP_EN : illegal opcodes halt in TRAP (left only by reset);
//                  when undefined they execute as a NOP and trap is tied to 0.
// Ports:
//   clk, reset_n       : clock (rising edge), async active-low reset
//   mem                : ctrl_if master (mem_req, mem_we, addr_sel / mem_ready)
//   opcode             : instruction register bits [6:0]
//   branch_taken       : ALU compare result for the current branch
//   write_ir, pc_write : IR / PC load enables
//   pc_sel, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op : datapath selects
//   mem_err            : one-cycle pulse on memory timeout
//   trap               : illegal-instruction halt
//   state_dbg          : current state encoding
// All outputs are forced to 0 while reset_n is low.
// -----------------------------------------------------------------------------
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   ctrl_if.master      mem,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   output logic        write_ir,
   output logic        pc_write,
   output logic        pc_sel,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        mem_err,
   output logic        trap,
   output logic [3:0]  state_dbg
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

   state_t     state_q;
   state_t     state_d;
   sel_t       sel_q;
   sel_t       sel_o;
   logic [7:0] wait_cnt;
   logic       in_mem;
   logic       timeout;

   op_class_t  op_class;
   logic       illegal;
   logic       is_load;
   logic       is_lui;

   ctrl_opdec u_opdec (
      .opcode   (opcode),
      .op_class (op_class),
      .illegal  (illegal),
      .is_load  (is_load),
      .is_lui   (is_lui)
   );

   assign in_mem  = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                    (state_q == ST_MEM_WR);
   // A ready in the limit cycle wins: the access completes normally.
   assign timeout = (MEM_WAIT_MAX != 0) && in_mem && !mem.mem_ready &&
                    (wait_cnt == WAIT_LIMIT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (timeout)            state_d = ST_FETCH;
            else if (mem.mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (illegal) begin
`ifdef CTRL_TRAP_EN
               state_d = ST_TRAP;
`else
               state_d = ST_FETCH;
`endif
            end else begin
               case (op_class)
                  CLS_MEM:    state_d = ST_MEM_ADDR;
                  CLS_R:      state_d = ST_EXEC_R;
                  CLS_I:      state_d = ST_EXEC_I;
                  CLS_BRANCH: state_d = ST_BRANCH;
                  CLS_JAL:    state_d = ST_JAL;
                  CLS_JALR:   state_d = ST_JALR;
                  CLS_UPPER:  state_d = ST_UPPER;
                  default:    state_d = ST_FETCH;
               endcase
            end
         end
         ST_MEM_ADDR: state_d = is_load ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD: begin
            if (timeout)            state_d = ST_FETCH;
            else if (mem.mem_ready) state_d = ST_MEM_WB;
         end
         ST_MEM_WR: begin
            if (timeout || mem.mem_ready) state_d = ST_FETCH;
         end
         ST_EXEC_R, ST_EXEC_I, ST_UPPER: state_d = ST_ALU_WB;
         ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR: state_d = ST_FETCH;
`ifdef CTRL_TRAP_EN
         ST_TRAP: state_d = ST_TRAP;
`endif
         default: state_d = ST_FETCH;
      endcase
   end

   // State-only selects are registered from the next state so they come
   // straight off flops, aligned with the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_FETCH;
         sel_q    <= sel_for(ST_FETCH, 1'b0);
         wait_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge
         // values regardless of statement order.
         state_q <= state_d;
         sel_q   <= sel_for(state_d, is_lui);
         // A timed-out FETCH stays in FETCH, so clear explicitly on timeout.
         if (timeout || (state_d != state_q))
            wait_cnt <= '0;
         else if (in_mem && !mem.mem_ready && (wait_cnt != 8'hFF))
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Reset gating makes mem_req drop asynchronously and zeroes every output.
   assign sel_o        = reset_n ? sel_q : '0;
   assign mem.mem_req  = sel_o.mem_req;
   assign mem.mem_we   = sel_o.mem_we;
   assign mem.addr_sel = sel_o.addr_sel;
   assign pc_sel       = sel_o.pc_sel;
   assign wb_sel       = sel_o.wb_sel;
   assign alu_src_a    = sel_o.alu_src_a;
   assign alu_src_b    = sel_o.alu_src_b;
   assign alu_op       = sel_o.alu_op;
   assign state_dbg    = reset_n ? state_q : 4'd0;

   // mem_ready is low on a timeout, so write_ir/pc_write stay off then.
   assign write_ir  = reset_n && (state_q == ST_FETCH) && mem.mem_ready;
   assign pc_write  = reset_n && (((state_q == ST_FETCH) && mem.mem_ready) ||
                                  ((state_q == ST_BRANCH) && branch_taken) ||
                                  (state_q == ST_JAL) || (state_q == ST_JALR));
   assign reg_write = reset_n && ((state_q == ST_MEM_WB) || (state_q == ST_ALU_WB) ||
                                  (state_q == ST_JAL) || (state_q == ST_JALR));
   assign mem_err   = reset_n && timeout;

`ifdef CTRL_TRAP_EN
   assign trap = reset_n && (state_q == ST_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_ctrl_fsm
// Scoreboard bench for ctrl_fsm (MEM_WAIT_MAX = 4). The stimulus process drives
// one cycle of inputs and pushes the hand-computed output vector for that
// cycle; the monitor pops and compares at every falling edge.
// Vector layout: {state, write_ir, pc_write, pc_sel, mem_req, mem_we, addr_sel,
//                 reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, mem_err, trap}
// -----------------------------------------------------------------------------
module tb_ctrl_fsm;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] opcode = OP_R;
   logic       branch_taken = 1'b0;
   logic       write_ir, pc_write, pc_sel, reg_write, mem_err, trap;
   logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
   logic [3:0] state_dbg;

   ctrl_if mem_bus ();

   ctrl_fsm #(.MEM_WAIT_MAX(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem          (mem_bus),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .write_ir     (write_ir),
      .pc_write     (pc_write),
      .pc_sel       (pc_sel),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .mem_err      (mem_err),
      .trap         (trap),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] vec(int st, int wir, int pcw, int pcs, int req,
                                       int we, int asel, int rw, int wb, int sa,
                                       int sb, int op, int err, int trp);
      return {st[3:0], wir[0], pcw[0], pcs[0], req[0], we[0], asel[0], rw[0],
              wb[1:0], sa[1:0], sb[1:0], op[1:0], err[0], trp[0]};
   endfunction

   //                                      st wir pcw pcs req we asl rw wb sa sb op er tr
   localparam logic [20:0] V_RST      = vec( 0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_FETCH    = vec( 0, 1,  1,  0,  1,  0, 0,  0, 0, 0, 2, 0, 0, 0);
   localparam logic [20:0] V_FETCH_W  = vec( 0, 0,  0,  0,  1,  0, 0,  0, 0, 0, 2, 0, 0, 0);
   localparam logic [20:0] V_FETCH_TO = vec( 0, 0,  0,  0,  1,  0, 0,  0, 0, 0, 2, 0, 1, 0);
   localparam logic [20:0] V_DECODE   = vec( 1, 0,  0,  0,  0,  0, 0,  0, 0, 2, 1, 0, 0, 0);
   localparam logic [20:0] V_MADDR    = vec( 2, 0,  0,  0,  0,  0, 0,  0, 0, 1, 1, 0, 0, 0);
   localparam logic [20:0] V_MRD      = vec( 3, 0,  0,  0,  1,  0, 1,  0, 0, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_MWB      = vec( 4, 0,  0,  0,  0,  0, 0,  1, 1, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_MWR      = vec( 5, 0,  0,  0,  1,  1, 1,  0, 0, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_MWR_TO   = vec( 5, 0,  0,  0,  1,  1, 1,  0, 0, 0, 0, 0, 1, 0);
   localparam logic [20:0] V_EXR      = vec( 6, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, 2, 0, 0);
   localparam logic [20:0] V_EXI      = vec( 7, 0,  0,  0,  0,  0, 0,  0, 0, 1, 1, 2, 0, 0);
   localparam logic [20:0] V_LUI      = vec( 8, 0,  0,  0,  0,  0, 0,  0, 0, 3, 1, 0, 0, 0);
   localparam logic [20:0] V_AUIPC    = vec( 8, 0,  0,  0,  0,  0, 0,  0, 0, 2, 1, 0, 0, 0);
   localparam logic [20:0] V_ALUWB    = vec( 9, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_BR_T     = vec(10, 0,  1,  1,  0,  0, 0,  0, 0, 1, 0, 1, 0, 0);
   localparam logic [20:0] V_BR_N     = vec(10, 0,  0,  1,  0,  0, 0,  0, 0, 1, 0, 1, 0, 0);
   localparam logic [20:0] V_JAL      = vec(11, 0,  1,  1,  0,  0, 0,  1, 2, 0, 0, 0, 0, 0);
   localparam logic [20:0] V_JALR     = vec(12, 0,  1,  0,  0,  0, 0,  1, 2, 1, 1, 0, 0, 0);
   localparam logic [20:0] V_TRAP     = vec(13, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 1);

   localparam logic [6:0] OP_ILL = 7'b1111111;

   typedef struct {
      string       name;
      logic [20:0] v;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [20:0] act;

   assign act = {state_dbg, write_ir, pc_write, pc_sel, mem_bus.mem_req, mem_bus.mem_we,
                 mem_bus.addr_sel, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                 mem_err, trap};

   // Monitor: compare the DUT against the oldest expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.v, $time);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(string nm, logic [20:0] v);
      exp_t e;
      e.name = nm;
      e.v    = v;
      sb_q.push_back(e);
   endtask

   task automatic cyc(string nm, logic [6:0] opc, logic mr, logic bt, logic [20:0] v);
      tick();
      opcode            = opc;
      mem_bus.mem_ready = mr;
      branch_taken      = bt;
      expect_now(nm, v);
   endtask

   initial begin
      mem_bus.mem_ready = 1'b1;
      cyc("reset0", OP_R, 1'b1, 1'b0, V_RST);
      cyc("reset1", OP_R, 1'b1, 1'b0, V_RST);
      tick();
      reset_n = 1'b1;
      expect_now("r_fetch", V_FETCH);
      cyc("r_decode", OP_R, 1'b1, 1'b0, V_DECODE);
      cyc("r_exec",   OP_R, 1'b1, 1'b0, V_EXR);
      cyc("r_wb",     OP_R, 1'b1, 1'b0, V_ALUWB);

      // Load with three wait cycles in MEM_RD: 8 cycles total.
      cyc("ld_fetch",  OP_LOAD, 1'b1, 1'b0, V_FETCH);
      cyc("ld_decode", OP_LOAD, 1'b1, 1'b0, V_DECODE);
      cyc("ld_addr",   OP_LOAD, 1'b1, 1'b0, V_MADDR);
      for (int i = 0; i < 3; i++) cyc("ld_rd_wait", OP_LOAD, 1'b0, 1'b0, V_MRD);
      cyc("ld_rd_done", OP_LOAD, 1'b1, 1'b0, V_MRD);
      cyc("ld_wb",      OP_LOAD, 1'b1, 1'b0, V_MWB);

      cyc("bt_fetch",  OP_BRANCH, 1'b1, 1'b0, V_FETCH);
      cyc("bt_decode", OP_BRANCH, 1'b1, 1'b0, V_DECODE);
      cyc("bt_taken",  OP_BRANCH, 1'b1, 1'b1, V_BR_T);
      cyc("bn_fetch",  OP_BRANCH, 1'b1, 1'b0, V_FETCH);
      cyc("bn_decode", OP_BRANCH, 1'b1, 1'b0, V_DECODE);
      cyc("bn_not",    OP_BRANCH, 1'b1, 1'b0, V_BR_N);

      cyc("st_fetch",  OP_STORE, 1'b1, 1'b0, V_FETCH);
      cyc("st_decode", OP_STORE, 1'b1, 1'b0, V_DECODE);
      cyc("st_addr",   OP_STORE, 1'b1, 1'b0, V_MADDR);
      cyc("st_wr",     OP_STORE, 1'b1, 1'b0, V_MWR);

      cyc("i_fetch",  OP_I, 1'b1, 1'b0, V_FETCH);
      cyc("i_decode", OP_I, 1'b1, 1'b0, V_DECODE);
      cyc("i_exec",   OP_I, 1'b1, 1'b0, V_EXI);
      cyc("i_wb",     OP_I, 1'b1, 1'b0, V_ALUWB);

      cyc("lui_fetch",  OP_LUI, 1'b1, 1'b0, V_FETCH);
      cyc("lui_decode", OP_LUI, 1'b1, 1'b0, V_DECODE);
      cyc("lui_upper",  OP_LUI, 1'b1, 1'b0, V_LUI);
      cyc("lui_wb",     OP_LUI, 1'b1, 1'b0, V_ALUWB);

      cyc("auipc_fetch",  OP_AUIPC, 1'b1, 1'b0, V_FETCH);
      cyc("auipc_decode", OP_AUIPC, 1'b1, 1'b0, V_DECODE);
      cyc("auipc_upper",  OP_AUIPC, 1'b1, 1'b0, V_AUIPC);
      cyc("auipc_wb",     OP_AUIPC, 1'b1, 1'b0, V_ALUWB);

      cyc("jal_fetch",  OP_JAL, 1'b1, 1'b0, V_FETCH);
      cyc("jal_decode", OP_JAL, 1'b1, 1'b0, V_DECODE);
      cyc("jal_exec",   OP_JAL, 1'b1, 1'b0, V_JAL);

      cyc("jalr_fetch",  OP_JALR, 1'b1, 1'b0, V_FETCH);
      cyc("jalr_decode", OP_JALR, 1'b1, 1'b0, V_DECODE);
      cyc("jalr_exec",   OP_JALR, 1'b1, 1'b0, V_JALR);

      // FETCH timeout: four wait cycles, then mem_err in the fifth, then refetch.
      for (int i = 0; i < 4; i++) cyc("to_fetch_wait", OP_R, 1'b0, 1'b0, V_FETCH_W);
      cyc("to_fetch_err", OP_R, 1'b0, 1'b0, V_FETCH_TO);
      cyc("to_refetch",   OP_R, 1'b1, 1'b0, V_FETCH);
      cyc("to_decode",    OP_R, 1'b1, 1'b0, V_DECODE);
      cyc("to_exec",      OP_R, 1'b1, 1'b0, V_EXR);
      cyc("to_wb",        OP_R, 1'b1, 1'b0, V_ALUWB);

      // Ready arriving exactly at the limit completes normally.
      for (int i = 0; i < 4; i++) cyc("edge_wait", OP_I, 1'b0, 1'b0, V_FETCH_W);
      cyc("edge_fetch_ok", OP_I, 1'b1, 1'b0, V_FETCH);
      cyc("edge_decode",   OP_I, 1'b1, 1'b0, V_DECODE);
      cyc("edge_exec",     OP_I, 1'b1, 1'b0, V_EXI);
      cyc("edge_wb",       OP_I, 1'b1, 1'b0, V_ALUWB);

      // MEM_WR timeout returns to FETCH.
      cyc("swto_fetch",  OP_STORE, 1'b1, 1'b0, V_FETCH);
      cyc("swto_decode", OP_STORE, 1'b1, 1'b0, V_DECODE);
      cyc("swto_addr",   OP_STORE, 1'b1, 1'b0, V_MADDR);
      for (int i = 0; i < 4; i++) cyc("swto_wait", OP_STORE, 1'b0, 1'b0, V_MWR);
      cyc("swto_err",    OP_STORE, 1'b0, 1'b0, V_MWR_TO);
      cyc("swto_back",   OP_STORE, 1'b0, 1'b0, V_FETCH_W);

      // Illegal opcode.
      cyc("ill_fetch",  OP_ILL, 1'b1, 1'b0, V_FETCH);
      cyc("ill_decode", OP_ILL, 1'b1, 1'b0, V_DECODE);
`ifdef CTRL_TRAP_EN
      cyc("ill_trap0", OP_ILL, 1'b0, 1'b0, V_TRAP);
      cyc("ill_trap1", OP_ILL, 1'b0, 1'b0, V_TRAP);
      cyc("ill_trap2", OP_ILL, 1'b1, 1'b1, V_TRAP);
`else
      cyc("ill_nop0", OP_ILL, 1'b0, 1'b0, V_FETCH_W);
      cyc("ill_nop1", OP_ILL, 1'b0, 1'b0, V_FETCH_W);
`endif
      tick();
      reset_n = 1'b0;
      expect_now("ill_reset", V_RST);
      tick();
      reset_n           = 1'b1;
      opcode            = OP_STORE;
      mem_bus.mem_ready = 1'b1;
      expect_now("post_rst_fetch", V_FETCH);

      // Reset asserted mid-cycle during a MEM_WR wait.
      cyc("rw_decode", OP_STORE, 1'b1, 1'b0, V_DECODE);
      cyc("rw_addr",   OP_STORE, 1'b1, 1'b0, V_MADDR);
      cyc("rw_wait0",  OP_STORE, 1'b0, 1'b0, V_MWR);
      cyc("rw_wait1",  OP_STORE, 1'b0, 1'b0, V_MWR);
      tick();
      #2;
      reset_n = 1'b0;
      expect_now("rw_async_reset", V_RST);
      tick();
      expect_now("rw_reset_hold", V_RST);
      tick();
      reset_n           = 1'b1;
      mem_bus.mem_ready = 1'b1;
      expect_now("final_fetch", V_FETCH);

      tick();
      tick();
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
